medidor_faixa_uc: RTL and testbench

// Control unit for the range-meter datapath (medidor_faixa_fd). Paces HC-SR04

---
 rtl/medidor_faixa_uc.sv | 198 +++++++++++++++++++
 tb/tb_medidor_faixa_uc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/medidor_faixa_uc.sv
// Control unit for the range-meter datapath (medidor_faixa_fd).
// Paces HC-SR04 measurements, sends each reading as "XYZ#" over the serial
// link, and once the in-range flag is set sends "AAA#" and parks.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   ligar                        run enable (level)
//   pronto_medida, pronto_tx     datapath done pulses
//   fim_time, fim_3sec           interval elapsed / in-range for 3 s
//   is_ultimo_char(_a)           char counters at the '#' index
//   zera .. acertou              datapath control strobes (registered)
//   db_estado                    current state encoding
module medidor_faixa_uc #(
    parameter int unsigned TIMEOUT_CICLOS = 3_000_000,
    parameter int unsigned TIMEOUT_BITS   = 22
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pronto_medida,
    input  logic       pronto_tx,
    input  logic       fim_time,
    input  logic       fim_3sec,
    input  logic       is_ultimo_char,
    input  logic       is_ultimo_char_a,
    output logic       zera,
    output logic       zera_time,
    output logic       conta_time,
    output logic       mensurar,
    output logic       zera_char,
    output logic       conta_prox_char,
    output logic       zera_char_a,
    output logic       conta_prox_char_a,
    output logic       partida_tx,
    output logic       registra_acertou,
    output logic       acertou,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL          = 4'd0,
        PREPARACAO       = 4'd1,
        ESPERA_INTERVALO = 4'd2,
        MEDIR            = 4'd3,
        AGUARDA_MEDIDA   = 4'd4,
        TRANSMITE        = 4'd5,
        ESPERA_TX        = 4'd6,
        PROX_CHAR        = 4'd7,
        VERIFICA         = 4'd8,
        REGISTRA         = 4'd9,
        TRANSMITE_A      = 4'd10,
        ESPERA_TX_A      = 4'd11,
        PROX_CHAR_A      = 4'd12,
        FIM_ACERTO       = 4'd13
    } estado_t;

    localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_MAX = TIMEOUT_BITS'(TIMEOUT_CICLOS - 1);

    estado_t                 estado_q, estado_d;
    logic [TIMEOUT_BITS-1:0] timeout_q, timeout_d;
    logic                    timeout_fim;

    logic zera_q, zera_time_q, conta_time_q, mensurar_q, zera_char_q;
    logic conta_prox_char_q, zera_char_a_q, conta_prox_char_a_q;
    logic partida_tx_q, registra_acertou_q, acertou_q;

    logic zera_d, zera_time_d, conta_time_d, mensurar_d, zera_char_d;
    logic conta_prox_char_d, zera_char_a_d, conta_prox_char_a_d;
    logic partida_tx_d, registra_acertou_d, acertou_d;

    assign timeout_fim = (timeout_q == TIMEOUT_MAX);

    // Next state and timeout counter; ligar=0 overrides every transition.
    always_comb begin
        estado_d  = estado_q;
        timeout_d = timeout_q;

        case (estado_q)
            INICIAL:          if (ligar) estado_d = PREPARACAO;
            PREPARACAO:       estado_d = ESPERA_INTERVALO;
            ESPERA_INTERVALO: if (fim_time) estado_d = MEDIR;
            MEDIR:            estado_d = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                // a measurement arriving on the timeout cycle is still accepted
                if (pronto_medida)    estado_d = TRANSMITE;
                else if (timeout_fim) estado_d = MEDIR;
            end
            TRANSMITE:        estado_d = ESPERA_TX;
            ESPERA_TX: begin
                if (pronto_tx) estado_d = is_ultimo_char ? VERIFICA : PROX_CHAR;
            end
            PROX_CHAR:        estado_d = TRANSMITE;
            VERIFICA:         estado_d = fim_3sec ? REGISTRA : ESPERA_INTERVALO;
            REGISTRA:         estado_d = TRANSMITE_A;
            TRANSMITE_A:      estado_d = ESPERA_TX_A;
            ESPERA_TX_A: begin
                if (pronto_tx) estado_d = is_ultimo_char_a ? FIM_ACERTO : PROX_CHAR_A;
            end
            PROX_CHAR_A:      estado_d = TRANSMITE_A;
            FIM_ACERTO:       estado_d = FIM_ACERTO;
            default:          estado_d = INICIAL;
        endcase

        if (!ligar) estado_d = INICIAL;

        // Timeout counter saturates so a stuck sensor never wraps it back.
        if (estado_q == MEDIR || estado_q == INICIAL) begin
            timeout_d = '0;
        end else if (estado_q == AGUARDA_MEDIDA && !timeout_fim) begin
            timeout_d = timeout_q + TIMEOUT_BITS'(1);
        end
    end

    // Outputs decoded from the next state so the registered strobes line up
    // with the state they belong to.
    always_comb begin
        zera_d              = 1'b0;
        zera_time_d         = 1'b0;
        conta_time_d        = 1'b0;
        mensurar_d          = 1'b0;
        zera_char_d         = 1'b0;
        conta_prox_char_d   = 1'b0;
        zera_char_a_d       = 1'b0;
        conta_prox_char_a_d = 1'b0;
        partida_tx_d        = 1'b0;
        registra_acertou_d  = 1'b0;
        acertou_d           = 1'b0;

        case (estado_d)
            PREPARACAO: begin
                zera_d        = 1'b1;
                zera_time_d   = 1'b1;
                zera_char_d   = 1'b1;
                zera_char_a_d = 1'b1;
            end
            ESPERA_INTERVALO: conta_time_d = 1'b1;
            MEDIR: begin
                mensurar_d  = 1'b1;
                zera_time_d = 1'b1;
            end
            TRANSMITE:   partida_tx_d        = 1'b1;
            PROX_CHAR:   conta_prox_char_d   = 1'b1;
            VERIFICA:    zera_char_d         = 1'b1;
            REGISTRA:    registra_acertou_d  = 1'b1;
            TRANSMITE_A: partida_tx_d        = 1'b1;
            PROX_CHAR_A: conta_prox_char_a_d = 1'b1;
            FIM_ACERTO:  acertou_d           = 1'b1;
            default: ;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q            <= INICIAL;
            timeout_q           <= '0;
            zera_q              <= 1'b0;
            zera_time_q         <= 1'b0;
            conta_time_q        <= 1'b0;
            mensurar_q          <= 1'b0;
            zera_char_q         <= 1'b0;
            conta_prox_char_q   <= 1'b0;
            zera_char_a_q       <= 1'b0;
            conta_prox_char_a_q <= 1'b0;
            partida_tx_q        <= 1'b0;
            registra_acertou_q  <= 1'b0;
            acertou_q           <= 1'b0;
        end else begin
            estado_q            <= estado_d;
            timeout_q           <= timeout_d;
            zera_q              <= zera_d;
            zera_time_q         <= zera_time_d;
            conta_time_q        <= conta_time_d;
            mensurar_q          <= mensurar_d;
            zera_char_q         <= zera_char_d;
            conta_prox_char_q   <= conta_prox_char_d;
            zera_char_a_q       <= zera_char_a_d;
            conta_prox_char_a_q <= conta_prox_char_a_d;
            partida_tx_q        <= partida_tx_d;
            registra_acertou_q  <= registra_acertou_d;
            acertou_q           <= acertou_d;
        end
    end

    assign zera              = zera_q;
    assign zera_time         = zera_time_q;
    assign conta_time        = conta_time_q;
    assign mensurar          = mensurar_q;
    assign zera_char         = zera_char_q;
    assign conta_prox_char   = conta_prox_char_q;
    assign zera_char_a       = zera_char_a_q;
    assign conta_prox_char_a = conta_prox_char_a_q;
    assign partida_tx        = partida_tx_q;
    assign registra_acertou  = registra_acertou_q;
    assign acertou           = acertou_q;
    assign db_estado         = 4'(estado_q);

endmodule

// File: tb/tb_medidor_faixa_uc.sv
// Directed bench for medidor_faixa_uc (timeout shortened to 8 clocks).
module tb_medidor_faixa_uc;

    logic       clock = 1'b0;
    logic       reset, ligar, pronto_medida, pronto_tx, fim_time, fim_3sec;
    logic       is_ultimo_char, is_ultimo_char_a;
    logic       zera, zera_time, conta_time, mensurar, zera_char, conta_prox_char;
    logic       zera_char_a, conta_prox_char_a, partida_tx, registra_acertou, acertou;
    logic [3:0] db_estado;
    logic [10:0] outs;

    int n_vec = 0;
    int n_err = 0;
    int c_zera, c_ptx, c_cpc, c_cpca, c_reg, c_mens;

    always #5 clock = ~clock;

    medidor_faixa_uc #(.TIMEOUT_CICLOS(8), .TIMEOUT_BITS(3)) dut (
        .clock(clock), .reset(reset), .ligar(ligar),
        .pronto_medida(pronto_medida), .pronto_tx(pronto_tx),
        .fim_time(fim_time), .fim_3sec(fim_3sec),
        .is_ultimo_char(is_ultimo_char), .is_ultimo_char_a(is_ultimo_char_a),
        .zera(zera), .zera_time(zera_time), .conta_time(conta_time),
        .mensurar(mensurar), .zera_char(zera_char), .conta_prox_char(conta_prox_char),
        .zera_char_a(zera_char_a), .conta_prox_char_a(conta_prox_char_a),
        .partida_tx(partida_tx), .registra_acertou(registra_acertou),
        .acertou(acertou), .db_estado(db_estado)
    );

    assign outs = {zera, zera_time, conta_time, mensurar, zera_char, conta_prox_char,
                   zera_char_a, conta_prox_char_a, partida_tx, registra_acertou, acertou};

    // Expected output vector per state, same bit order as outs.
    function automatic logic [10:0] exp_out(input int s);
        case (s)
            1:       return 11'b11001010000;
            2:       return 11'b00100000000;
            3:       return 11'b01010000000;
            5, 10:   return 11'b00000000100;
            7:       return 11'b00000100000;
            8:       return 11'b00001000000;
            9:       return 11'b00000000010;
            12:      return 11'b00000001000;
            13:      return 11'b00000000001;
            default: return 11'b00000000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int s);
        chk({tag, "_st"}, 32'(db_estado), 32'(s));
        chk({tag, "_out"}, 32'(outs), 32'(exp_out(s)));
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        c_zera += int'(zera);
        c_ptx  += int'(partida_tx);
        c_cpc  += int'(conta_prox_char);
        c_cpca += int'(conta_prox_char_a);
        c_reg  += int'(registra_acertou);
        c_mens += int'(mensurar);
    endtask

    task automatic clr_cnt();
        c_zera = 0; c_ptx = 0; c_cpc = 0; c_cpca = 0; c_reg = 0; c_mens = 0;
    endtask

    // Starts in a transmit state; sends four chars with pronto_tx 15 clk after each start.
    task automatic send_frame(input bit a);
        int st_tx, st_wt, st_nx;
        st_tx = a ? 10 : 5;
        st_wt = a ? 11 : 6;
        st_nx = a ? 12 : 7;
        for (int k = 0; k < 4; k++) begin
            chk_state(a ? "tx_a" : "tx", st_tx);
            tick();
            chk_state(a ? "wait_a" : "wait", st_wt);
            for (int i = 0; i < 13; i++) tick();
            chk_state(a ? "wait_a_hold" : "wait_hold", st_wt);
            pronto_tx = 1'b1;
            if (a) is_ultimo_char_a = (k == 3);
            else   is_ultimo_char   = (k == 3);
            tick();
            pronto_tx = 1'b0; is_ultimo_char = 1'b0; is_ultimo_char_a = 1'b0;
            if (k < 3) begin
                chk_state(a ? "next_a" : "next", st_nx);
                tick();
            end
        end
    endtask

    initial begin
        int bad;
        reset = 1'b1; ligar = 1'b0; pronto_medida = 1'b0; pronto_tx = 1'b0;
        fim_time = 1'b0; fim_3sec = 1'b0; is_ultimo_char = 1'b0; is_ultimo_char_a = 1'b0;
        clr_cnt();

        // 1: reset, then idle with ligar=0
        tick(); tick();
        chk_state("reset", 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (db_estado !== 4'd0 || outs !== 11'd0) bad++;
        end
        chk("idle_100", 32'(bad), 32'd0);

        // 2: one measurement frame without the 3 s flag
        clr_cnt();
        ligar = 1'b1;
        tick(); chk_state("prep", 1);
        tick(); chk_state("interval", 2);
        for (int i = 0; i < 9; i++) tick();
        chk_state("interval_hold", 2);
        fim_time = 1'b1;
        tick(); chk_state("medir", 3);
        fim_time = 1'b0;
        tick(); chk_state("aguarda", 4);
        tick(); tick(); tick();
        chk_state("aguarda_hold", 4);
        pronto_medida = 1'b1;
        tick();
        pronto_medida = 1'b0;
        send_frame(1'b0);
        chk_state("verifica", 8);
        tick(); chk_state("back_interval", 2);
        chk("t2_zera", 32'(c_zera), 32'd1);
        chk("t2_ptx", 32'(c_ptx), 32'd4);
        chk("t2_cpc", 32'(c_cpc), 32'd3);
        chk("t2_mens", 32'(c_mens), 32'd1);

        // 3: frame followed by the "AAA#" frame
        clr_cnt();
        fim_time = 1'b1;
        tick(); chk_state("t3_medir", 3);
        fim_time = 1'b0;
        pronto_medida = 1'b1;
        tick(); chk_state("t3_aguarda", 4);
        tick();
        pronto_medida = 1'b0;
        send_frame(1'b0);
        chk_state("t3_verifica", 8);
        fim_3sec = 1'b1;
        tick(); chk_state("registra", 9);
        tick();
        send_frame(1'b1);
        chk_state("fim_acerto", 13);
        for (int i = 0; i < 5; i++) tick();
        chk_state("fim_acerto_hold", 13);
        chk("t3_reg", 32'(c_reg), 32'd1);
        chk("t3_ptx", 32'(c_ptx), 32'd8);
        chk("t3_cpc", 32'(c_cpc), 32'd3);
        chk("t3_cpca", 32'(c_cpca), 32'd3);
        ligar = 1'b0;
        tick(); chk_state("t3_off", 0);
        fim_3sec = 1'b0;

        // 4: measurement timeout re-trigger every 9 clocks, then coincidence
        ligar = 1'b1;
        tick(); chk_state("t4_prep", 1);
        tick(); chk_state("t4_interval", 2);
        fim_time = 1'b1;
        clr_cnt();
        tick(); chk_state("t4_medir0", 3);
        fim_time = 1'b0;
        for (int r = 0; r < 2; r++) begin
            bad = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (db_estado !== 4'd4) bad++;
            end
            chk("t4_wait8", 32'(bad), 32'd0);
            tick(); chk_state("t4_retrig", 3);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (db_estado !== 4'd4) bad++;
        end
        chk("t4_wait8_last", 32'(bad), 32'd0);
        pronto_medida = 1'b1;
        tick(); chk_state("t4_coincide", 5);
        pronto_medida = 1'b0;
        chk("t4_mens", 32'(c_mens), 32'd3);

        // 5: ligar dropped during espera_tx, then restart
        tick(); chk_state("t5_wait", 6);
        ligar = 1'b0;
        tick(); chk_state("t5_off", 0);
        ligar = 1'b1;
        tick(); chk_state("t5_prep", 1);

        // 6: reset during espera_tx_a
        tick(); chk_state("t6_interval", 2);
        fim_time = 1'b1; pronto_medida = 1'b1;
        tick(); chk_state("t6_medir", 3);
        fim_time = 1'b0;
        tick(); tick();
        pronto_medida = 1'b0;
        send_frame(1'b0);
        fim_3sec = 1'b1;
        tick(); chk_state("t6_registra", 9);
        tick(); chk_state("t6_tx_a", 10);
        tick(); chk_state("t6_wait_a", 11);
        reset = 1'b1;
        tick(); chk_state("t6_reset", 0);
        chk("t6_acertou", 32'(acertou), 32'd0);
        reset = 1'b0;
        tick(); chk_state("t6_restart", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
